// File: rtl/a09_ctrl_pkg.sv
// a09_ctrl_pkg: shared encodings for the A09 reset-vector control matrix.
//   - state_e       : control matrix state encoding (2 bits)
//   - PC_SRC_*      : PC-source mux select codes
//   - ADDR_SRC_*    : address-source mux select codes
//   - *_SELECT_SIZE : select widths of the PC and address muxes
package a09_ctrl_pkg;

    localparam int unsigned PC_SELECT_SIZE   = 3;
    localparam int unsigned ADDR_SELECT_SIZE = 2;

    localparam logic [PC_SELECT_SIZE-1:0]   PC_SRC_ZERO      = 3'd0;
    localparam logic [PC_SELECT_SIZE-1:0]   PC_SRC_RESET_VEC = 3'd2;
    localparam logic [ADDR_SELECT_SIZE-1:0] ADDR_SRC_PC      = 2'd0;

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_VECTOR   = 2'd1,
        S_LOAD_MAR = 2'd2,
        S_IDLE     = 2'd3
    } state_e;

endpackage

// File: rtl/mux4.sv
// mux4: generic combinational 4:1 multiplexer.
// Ports:
//   select_i [1:0]            : input select
//   data0_i..data3_i [DW-1:0] : data inputs (tie unused inputs to zero)
//   data_o   [DW-1:0]         : selected data
module mux4 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [1:0]            select_i,
    input  logic [DATA_WIDTH-1:0] data0_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    input  logic [DATA_WIDTH-1:0] data3_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = '0;
        unique case (select_i)
            2'd0: data_o = data0_i;
            2'd1: data_o = data1_i;
            2'd2: data_o = data2_i;
            2'd3: data_o = data3_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mux8.sv
// mux8: generic combinational 8:1 multiplexer.
// Ports:
//   select_i [2:0]            : input select
//   data0_i..data7_i [DW-1:0] : data inputs (tie unused inputs to zero)
//   data_o   [DW-1:0]         : selected data
module mux8 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [2:0]            select_i,
    input  logic [DATA_WIDTH-1:0] data0_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    input  logic [DATA_WIDTH-1:0] data3_i,
    input  logic [DATA_WIDTH-1:0] data4_i,
    input  logic [DATA_WIDTH-1:0] data5_i,
    input  logic [DATA_WIDTH-1:0] data6_i,
    input  logic [DATA_WIDTH-1:0] data7_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = '0;
        unique case (select_i)
            3'd0: data_o = data0_i;
            3'd1: data_o = data1_i;
            3'd2: data_o = data2_i;
            3'd3: data_o = data3_i;
            3'd4: data_o = data4_i;
            3'd5: data_o = data5_i;
            3'd6: data_o = data6_i;
            3'd7: data_o = data7_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mealy_control_matrix.sv
// mealy_control_matrix: sequences the A09 reset-vector fetch.
// After reset release it holds PC/MAR in reset one cycle, loads the PC with
// the reset vector, then loads the MAR from the PC and idles.
// Ports:
//   clk_i      : system clock, rising edge
//   reset_ni   : synchronous active-low reset
//   pc_rst_no  : PC reset strobe (active low)
//   pc_ld_no   : PC load strobe (active low)
//   mar_rst_no : MAR reset strobe (active low)
//   mar_ld_no  : MAR load strobe (active low)
//   pc_src_o   : PC-source mux select
//   addr_src_o : address-source mux select
module mealy_control_matrix
    import a09_ctrl_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        reset_ni,
    output logic                        pc_rst_no,
    output logic                        pc_ld_no,
    output logic                        mar_rst_no,
    output logic                        mar_ld_no,
    output logic [PC_SELECT_SIZE-1:0]   pc_src_o,
    output logic [ADDR_SELECT_SIZE-1:0] addr_src_o
);

    // Power-up value keeps behaviour deterministic before the first reset.
    state_e state_q = S_RESET;
    state_e state_d;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_rst_no  = 1'b1;
        pc_ld_no   = 1'b1;
        mar_rst_no = 1'b1;
        mar_ld_no  = 1'b1;
        pc_src_o   = PC_SRC_ZERO;
        addr_src_o = ADDR_SRC_PC;

        if (!reset_ni) begin
            // Mealy override: downstream registers clear on the same edge
            // that returns the matrix to S_RESET.
            pc_rst_no  = 1'b0;
            mar_rst_no = 1'b0;
            state_d    = S_RESET;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    pc_rst_no  = 1'b0;
                    mar_rst_no = 1'b0;
                    state_d    = S_VECTOR;
                end
                S_VECTOR: begin
                    pc_src_o = PC_SRC_RESET_VEC;
                    pc_ld_no = 1'b0;
                    state_d  = S_LOAD_MAR;
                end
                S_LOAD_MAR: begin
                    addr_src_o = ADDR_SRC_PC;
                    mar_ld_no  = 1'b0;
                    state_d    = S_IDLE;
                end
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_control_matrix.sv
// Directed bench for mealy_control_matrix with a PC/MAR datapath built from
// mux8/mux4, plus standalone mux8/mux4 checks.
module tb_mealy_control_matrix;
    import a09_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pc_rst_n, pc_ld_n, mar_rst_n, mar_ld_n;
    logic [2:0] pc_src;
    logic [1:0] addr_src;

    always #5 clk = ~clk;

    mealy_control_matrix dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .pc_rst_no  (pc_rst_n),
        .pc_ld_no   (pc_ld_n),
        .mar_rst_no (mar_rst_n),
        .mar_ld_no  (mar_ld_n),
        .pc_src_o   (pc_src),
        .addr_src_o (addr_src)
    );

    // {pc_rst_n, pc_ld_n, mar_rst_n, mar_ld_n, pc_src, addr_src}
    logic [8:0] outs;
    assign outs = {pc_rst_n, pc_ld_n, mar_rst_n, mar_ld_n, pc_src, addr_src};

    localparam logic [8:0] OUT_RST  = {4'b0101, 3'd0, 2'd0};
    localparam logic [8:0] OUT_VEC  = {4'b1011, 3'd2, 2'd0};
    localparam logic [8:0] OUT_MAR  = {4'b1110, 3'd0, 2'd0};
    localparam logic [8:0] OUT_IDLE = {4'b1111, 3'd0, 2'd0};

    // Attached datapath: PC and MAR registers steered by the matrix.
    logic [7:0] pc_q, mar_q, pc_mux, addr_mux;

    mux8 #(.DATA_WIDTH(8)) u_pc_mux (
        .select_i (pc_src),
        .data0_i  (8'h00),
        .data1_i  (8'h00),
        .data2_i  (8'hFF),
        .data3_i  (8'h00),
        .data4_i  (8'h00),
        .data5_i  (8'h00),
        .data6_i  (8'h00),
        .data7_i  (8'h00),
        .data_o   (pc_mux)
    );

    mux4 #(.DATA_WIDTH(8)) u_addr_mux (
        .select_i (addr_src),
        .data0_i  (pc_q),
        .data1_i  (8'h00),
        .data2_i  (8'h00),
        .data3_i  (8'h00),
        .data_o   (addr_mux)
    );

    always @(posedge clk) begin
        if (!pc_rst_n) pc_q <= 8'h00;
        else if (!pc_ld_n) pc_q <= pc_mux;
        if (!mar_rst_n) mar_q <= 8'h00;
        else if (!mar_ld_n) mar_q <= addr_mux;
    end

    // Standalone mux instances.
    logic [2:0] m8_sel;
    logic [1:0] m4_sel;
    logic [7:0] m8_full_o, m8_part_o, m4_o;

    mux8 #(.DATA_WIDTH(8)) u_m8_full (
        .select_i (m8_sel),
        .data0_i  (8'h10), .data1_i (8'h11), .data2_i (8'h12), .data3_i (8'h13),
        .data4_i  (8'h14), .data5_i (8'h15), .data6_i (8'h16), .data7_i (8'h17),
        .data_o   (m8_full_o)
    );

    mux8 #(.DATA_WIDTH(8)) u_m8_part (
        .select_i (m8_sel),
        .data0_i  (8'h10), .data1_i (8'h11), .data2_i (8'h12), .data3_i (8'h13),
        .data4_i  (8'h00), .data5_i (8'h00), .data6_i (8'h00), .data7_i (8'h00),
        .data_o   (m8_part_o)
    );

    mux4 #(.DATA_WIDTH(8)) u_m4 (
        .select_i (m4_sel),
        .data0_i  (8'hA0), .data1_i (8'hA1), .data2_i (8'hA2), .data3_i (8'hA3),
        .data_o   (m4_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_st(input string tag, input state_e exp_st, input logic [8:0] exp_out);
        check_eq({tag, ".state"}, 32'(dut.state_q), 32'(exp_st));
        check_eq({tag, ".outs"}, 32'(outs), 32'(exp_out));
    endtask

    initial begin
        m8_sel = 3'd0;
        m4_sel = 2'd0;

        // Power-up without reset.
        #1;
        check_st("pu0", S_RESET, OUT_RST);
        step();
        check_st("pu1", S_VECTOR, OUT_VEC);
        check_eq("pu1.pc", 32'(pc_q), 32'h00);
        step();
        check_st("pu2", S_LOAD_MAR, OUT_MAR);
        check_eq("pu2.pc", 32'(pc_q), 32'hFF);
        step();
        check_st("pu3", S_IDLE, OUT_IDLE);
        check_eq("pu3.mar", 32'(mar_q), 32'hFF);
        step();
        check_st("pu4", S_IDLE, OUT_IDLE);

        // Reset asserted from idle: combinational override before any edge.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_st("rst_comb", S_IDLE, OUT_RST);
        for (int i = 0; i < 2; i++) begin
            step();
            check_st("rst_hold", S_RESET, OUT_RST);
        end
        check_eq("rst.pc", 32'(pc_q), 32'h00);
        check_eq("rst.mar", 32'(mar_q), 32'h00);

        // Release with datapath attached.
        reset_n = 1'b1;
        #1;
        check_st("rel0", S_RESET, OUT_RST);
        step();
        check_st("rel1", S_VECTOR, OUT_VEC);
        check_eq("rel1.pc", 32'(pc_q), 32'h00);
        step();
        check_st("rel2", S_LOAD_MAR, OUT_MAR);
        check_eq("rel2.pc", 32'(pc_q), 32'hFF);
        check_eq("rel2.mar", 32'(mar_q), 32'h00);
        step();
        check_st("rel3", S_IDLE, OUT_IDLE);
        check_eq("rel3.mar", 32'(mar_q), 32'hFF);
        step();
        check_st("rel4", S_IDLE, OUT_IDLE);
        check_eq("rel4.pc", 32'(pc_q), 32'hFF);
        check_eq("rel4.mar", 32'(mar_q), 32'hFF);

        // Reset during S_VECTOR.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check_st("mid_vec", S_VECTOR, OUT_VEC);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_st("mid_comb", S_VECTOR, OUT_RST);
        step();
        check_st("mid_rst", S_RESET, OUT_RST);
        check_eq("mid_rst.pc", 32'(pc_q), 32'h00);
        check_eq("mid_rst.mar", 32'(mar_q), 32'h00);
        reset_n = 1'b1;
        step();
        check_st("rep1", S_VECTOR, OUT_VEC);
        step();
        check_st("rep2", S_LOAD_MAR, OUT_MAR);
        check_eq("rep2.pc", 32'(pc_q), 32'hFF);
        step();
        check_st("rep3", S_IDLE, OUT_IDLE);
        check_eq("rep3.mar", 32'(mar_q), 32'hFF);

        // Standalone muxes.
        for (int k = 0; k < 8; k++) begin
            m8_sel = 3'(k);
            #1;
            check_eq($sformatf("m8_full.%0d", k), 32'(m8_full_o), 32'(8'h10 + k));
            check_eq($sformatf("m8_part.%0d", k), 32'(m8_part_o),
                     (k < 4) ? 32'(8'h10 + k) : 32'h00);
        end
        for (int k = 0; k < 4; k++) begin
            m4_sel = 2'(k);
            #0;
            #1;
            check_eq($sformatf("m4.%0d", k), 32'(m4_o), 32'(8'hA0 + k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
